// File: rtl/image_load_controller.sv
// Load sequencer for the BNN row-stream image decoder: accepts one row byte at a
// time, writes it into its decoder row slot, then hands the frame to the BNN core.
module image_load_controller #(
    parameter int ROWS  = 8,
    parameter int ROW_W = 8,
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [ROW_W-1:0] byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    input  logic             frame_abort_i,
    output logic [ROW_W-1:0] dec_slice_o,
    output logic [SEL_W-1:0] dec_sel_o,
    output logic             dec_en_o,
    output logic             core_start_o,
    input  logic             core_busy_i,
    input  logic             core_done_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   row_cnt_q, row_cnt_d;
    logic               acc_q, acc_d;
    logic               dec_en_q, dec_en_d;
    logic [ROW_W-1:0]   dec_slice_q, dec_slice_d;
    logic [SEL_W-1:0]   dec_sel_q, dec_sel_d;
    logic               core_start_q, core_start_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               accept;
    logic               last_row;

    // The decoder needs select stable for one cycle after it registers a slice,
    // so the cycle following an acceptance is never ready.
    assign byte_ready_o = (state_q == LOAD) && !acc_q && !frame_abort_i;
    assign accept       = byte_valid_i && byte_ready_o;
    assign last_row     = (row_cnt_q == SEL_W'(ROWS - 1));

    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        acc_d        = accept;
        dec_en_d     = accept;
        dec_slice_d  = dec_slice_q;
        dec_sel_d    = dec_sel_q;
        core_start_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        if (accept) begin
            dec_slice_d = byte_i;
            dec_sel_d   = row_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (frame_abort_i) begin
                    row_cnt_d = '0;
                end else if (accept) begin
                    if (last_row) begin
                        row_cnt_d = '0;
                        state_d   = START;
                    end else begin
                        row_cnt_d = row_cnt_q + SEL_W'(1);
                    end
                end
            end
            START: begin
                if (!core_busy_i) begin
                    core_start_d = 1'b1;
                    state_d      = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_done_i) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = enable_i ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            row_cnt_q    <= '0;
            acc_q        <= 1'b0;
            dec_en_q     <= 1'b0;
            dec_slice_q  <= '0;
            dec_sel_q    <= '0;
            core_start_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            acc_q        <= acc_d;
            dec_en_q     <= dec_en_d;
            dec_slice_q  <= dec_slice_d;
            dec_sel_q    <= dec_sel_d;
            core_start_q <= core_start_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign dec_en_o     = dec_en_q;
    assign dec_slice_o  = dec_slice_q;
    assign dec_sel_o    = dec_sel_q;
    assign core_start_o = core_start_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_image_load_controller.sv
// Directed bench for image_load_controller; a negedge monitor records handshakes,
// decoder writes and core starts, and each scenario task checks what it drove.
module tb_image_load_controller;

    localparam int ROWS  = 8;
    localparam int ROW_W = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable_i = 1'b0;
    logic [ROW_W-1:0] byte_i = '0;
    logic             byte_valid_i = 1'b0;
    logic             byte_ready_o;
    logic             frame_abort_i = 1'b0;
    logic [ROW_W-1:0] dec_slice_o;
    logic [SEL_W-1:0] dec_sel_o;
    logic             dec_en_o;
    logic             core_start_o;
    logic             core_busy_i = 1'b0;
    logic             core_done_i = 1'b0;
    logic             busy_o;
    logic [CNT_W-1:0] frame_cnt_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int               acc_cyc[$];
    int               en_cyc[$];
    logic [SEL_W-1:0] en_sel[$];
    logic [ROW_W-1:0] en_slice[$];
    int               start_cyc[$];

    image_load_controller #(.ROWS(ROWS), .ROW_W(ROW_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i), .byte_i(byte_i),
        .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .frame_abort_i(frame_abort_i), .dec_slice_o(dec_slice_o), .dec_sel_o(dec_sel_o),
        .dec_en_o(dec_en_o), .core_start_o(core_start_o), .core_busy_i(core_busy_i),
        .core_done_i(core_done_i), .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid_i && byte_ready_o) acc_cyc.push_back(cyc);
        if (dec_en_o) begin
            en_cyc.push_back(cyc);
            en_sel.push_back(dec_sel_o);
            en_slice.push_back(dec_slice_o);
        end
        if (core_start_o) start_cyc.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim_time=%0t limit=2000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        acc_cyc.delete(); en_cyc.delete(); en_sel.delete(); en_slice.delete(); start_cyc.delete();
    endtask

    task automatic send_row(input logic [ROW_W-1:0] b, input int gap);
        bit ok = 0;
        if (gap > 0) begin
            byte_valid_i = 1'b0;
            repeat (gap) step();
        end
        byte_i = b;
        byte_valid_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (byte_ready_o) begin ok = 1; break; end
        end
        step();
        checks++;
        if (!ok) begin failures++; $display("FAIL row_accept byte=%0h accepted=0 required=1", b); end
    endtask

    // gapmode < 0: valid held high; otherwise gap before row i is (i+gapmode)%4
    task automatic send_frame(input logic [8*ROW_W-1:0] fr, input int gapmode);
        for (int i = 0; i < ROWS; i++)
            send_row(fr[8*i +: 8], (gapmode < 0) ? 0 : (i + gapmode) % 4);
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_start();
        for (int k = 0; k < 40; k++) begin
            if (start_cyc.size() > 0) break;
            step();
        end
        checks++;
        if (start_cyc.size() == 0) begin failures++; $display("FAIL start_timeout got=none required=pulse"); end
    endtask

    task automatic pulse_done();
        core_done_i = 1'b1;
        step();
        core_done_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable_i = 1'b0; byte_valid_i = 1'b1; core_done_i = 1'b1;
        repeat (3) step();
        checks++; if (dec_en_o !== 1'b0) begin failures++; $display("FAIL rst_dec_en got=%0b exp=0", dec_en_o); end
        checks++; if (dec_sel_o !== 3'd0) begin failures++; $display("FAIL rst_dec_sel got=%0d exp=0", dec_sel_o); end
        checks++; if (dec_slice_o !== 8'h00) begin failures++; $display("FAIL rst_dec_slice got=%0h exp=0", dec_slice_o); end
        checks++; if (core_start_o !== 1'b0) begin failures++; $display("FAIL rst_start got=%0b exp=0", core_start_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy_o); end
        checks++; if (byte_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", byte_ready_o); end
        checks++; if (frame_cnt_o !== 2'd0) begin failures++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt_o); end
        reset = 1'b0; byte_valid_i = 1'b0; core_done_i = 1'b0;
        step();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_hold busy got=%0b exp=0", busy_o); end
    endtask

    task automatic test_stream();
        logic [63:0] fr = 64'h18244281_18244281;
        clear_log();
        enable_i = 1'b1;
        send_frame(fr, -1);
        wait_start();
        repeat (3) step();
        checks++; if (acc_cyc.size() != 8) begin failures++; $display("FAIL s1_accepts got=%0d exp=8", acc_cyc.size()); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++; if (acc_cyc[i] - acc_cyc[i-1] != 2) begin failures++; $display("FAIL s1_spacing row=%0d got=%0d exp=2", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
        checks++; if (en_cyc.size() != 8) begin failures++; $display("FAIL s1_dec_en_count got=%0d exp=8", en_cyc.size()); end
        for (int i = 0; i < 8 && i < en_cyc.size() && i < acc_cyc.size(); i++) begin
            checks++; if (en_cyc[i] != acc_cyc[i] + 1) begin failures++; $display("FAIL s1_en_latency row=%0d got=%0d exp=%0d", i, en_cyc[i], acc_cyc[i] + 1); end
            checks++; if (en_sel[i] !== 3'(i)) begin failures++; $display("FAIL s1_sel row=%0d got=%0d exp=%0d", i, en_sel[i], i); end
            checks++; if (en_slice[i] !== fr[8*i +: 8]) begin failures++; $display("FAIL s1_slice row=%0d got=%0h exp=%0h", i, en_slice[i], fr[8*i +: 8]); end
        end
        checks++; if (start_cyc.size() != 1) begin failures++; $display("FAIL s1_start_count got=%0d exp=1", start_cyc.size()); end
        if (start_cyc.size() > 0 && en_cyc.size() == 8) begin
            checks++; if (start_cyc[0] != en_cyc[7] + 1) begin failures++; $display("FAIL s1_start_time got=%0d exp=%0d", start_cyc[0], en_cyc[7] + 1); end
        end
    endtask

    task automatic test_second_frame();
        logic [63:0] fr = 64'hF0E1D2C3_B4A59687;
        pulse_done();
        checks++; if (frame_cnt_o !== 2'd1) begin failures++; $display("FAIL s2_frame_cnt got=%0d exp=1", frame_cnt_o); end
        checks++; if (byte_ready_o !== 1'b1) begin failures++; $display("FAIL s2_back_in_load ready got=%0b exp=1", byte_ready_o); end
        clear_log();
        send_frame(fr, -1);
        wait_start();
        checks++; if (en_sel.size() != 8) begin failures++; $display("FAIL s2_dec_en_count got=%0d exp=8", en_sel.size()); end
        for (int i = 0; i < 8 && i < en_sel.size(); i++) begin
            checks++; if (en_sel[i] !== 3'(i) || en_slice[i] !== fr[8*i +: 8]) begin failures++; $display("FAIL s2_row row=%0d got=%0d/%0h exp=%0d/%0h", i, en_sel[i], en_slice[i], i, fr[8*i +: 8]); end
        end
        pulse_done();
        checks++; if (frame_cnt_o !== 2'd2) begin failures++; $display("FAIL s2_frame_cnt2 got=%0d exp=2", frame_cnt_o); end
    endtask

    task automatic test_core_busy();
        clear_log();
        core_busy_i = 1'b1;
        send_frame(64'h01020304_05060708, -1);
        byte_i = 8'hEE; byte_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (core_start_o !== 1'b0 || byte_ready_o !== 1'b0) begin failures++; $display("FAIL s3_held_off cyc=%0d start/ready got=%0b/%0b exp=0/0", k, core_start_o, byte_ready_o); end
            step();
        end
        core_busy_i = 1'b0;
        @(negedge clk);
        checks++; if (core_start_o !== 1'b0) begin failures++; $display("FAIL s3_start_early got=%0b exp=0", core_start_o); end
        step();
        @(negedge clk);
        checks++; if (core_start_o !== 1'b1 || byte_ready_o !== 1'b0) begin failures++; $display("FAIL s3_start_fire start/ready got=%0b/%0b exp=1/0", core_start_o, byte_ready_o); end
        step();
        byte_valid_i = 1'b0;
        step();
        checks++; if (start_cyc.size() != 1) begin failures++; $display("FAIL s3_start_count got=%0d exp=1", start_cyc.size()); end
        checks++; if (acc_cyc.size() != 8) begin failures++; $display("FAIL s3_accepts got=%0d exp=8", acc_cyc.size()); end
        pulse_done();
        checks++; if (frame_cnt_o !== 2'd3) begin failures++; $display("FAIL s3_frame_cnt got=%0d exp=3", frame_cnt_o); end
    endtask

    task automatic test_abort();
        logic [63:0] fr = 64'h99887766_44332211;
        clear_log();
        send_row(8'h11, 0); send_row(8'h22, 0); send_row(8'h33, 0);
        byte_valid_i = 1'b0;
        step();
        byte_i = 8'h55; byte_valid_i = 1'b1; frame_abort_i = 1'b1;
        #1;
        checks++; if (byte_ready_o !== 1'b0) begin failures++; $display("FAIL s4_abort_ready got=%0b exp=0", byte_ready_o); end
        step();
        frame_abort_i = 1'b0; byte_valid_i = 1'b0;
        step();
        checks++; if (en_cyc.size() != 3 || acc_cyc.size() != 3) begin failures++; $display("FAIL s4_abort_byte en/acc got=%0d/%0d exp=3/3", en_cyc.size(), acc_cyc.size()); end
        clear_log();
        send_frame(fr, -1);
        wait_start();
        checks++; if (en_cyc.size() != 8) begin failures++; $display("FAIL s4_rows got=%0d exp=8", en_cyc.size()); end
        for (int i = 0; i < 8 && i < en_cyc.size(); i++) begin
            checks++; if (en_sel[i] !== 3'(i) || en_slice[i] !== fr[8*i +: 8]) begin failures++; $display("FAIL s4_row row=%0d got=%0d/%0h exp=%0d/%0h", i, en_sel[i], en_slice[i], i, fr[8*i +: 8]); end
        end
        if (en_cyc.size() == 8 && start_cyc.size() > 0) begin
            checks++; if (start_cyc[0] != en_cyc[7] + 1) begin failures++; $display("FAIL s4_start_time got=%0d exp=%0d", start_cyc[0], en_cyc[7] + 1); end
        end
        pulse_done();
        checks++; if (frame_cnt_o !== 2'd0) begin failures++; $display("FAIL s4_frame_cnt_wrap got=%0d exp=0", frame_cnt_o); end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] fr = 64'h0F1E2D3C_4B5A6978;
        clear_log();
        for (int i = 0; i < 5; i++) send_row(8'hA0 + 8'(i), 0);
        byte_valid_i = 1'b0;
        step();
        byte_i = 8'hF0; byte_valid_i = 1'b1; reset = 1'b1;
        step();
        checks++; if (dec_en_o !== 1'b0 || core_start_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL s5_load_reset en/start/busy got=%0b/%0b/%0b exp=0/0/0", dec_en_o, core_start_o, busy_o); end
        checks++; if (dec_sel_o !== 3'd0 || dec_slice_o !== 8'h00) begin failures++; $display("FAIL s5_load_reset sel/slice got=%0d/%0h exp=0/0", dec_sel_o, dec_slice_o); end
        reset = 1'b0; byte_valid_i = 1'b0;
        step();
        checks++; if (dec_en_o !== 1'b0 || core_start_o !== 1'b0) begin failures++; $display("FAIL s5_after_reset en/start got=%0b/%0b exp=0/0", dec_en_o, core_start_o); end
        clear_log();
        send_frame(fr, -1);
        wait_start();
        checks++; if (en_sel.size() != 8 || en_sel[0] !== 3'd0 || en_slice[0] !== 8'h78) begin failures++; $display("FAIL s5_restart rows/sel0/slice0 got=%0d/%0d/%0h exp=8/0/78", en_sel.size(), en_sel[0], en_slice[0]); end
        pulse_done();
        checks++; if (frame_cnt_o !== 2'd1) begin failures++; $display("FAIL s5_frame_cnt got=%0d exp=1", frame_cnt_o); end
        clear_log();
        send_frame(fr, -1);
        wait_start();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; enable_i = 1'b0;
        checks++; if (frame_cnt_o !== 2'd0 || busy_o !== 1'b0 || core_start_o !== 1'b0 || dec_en_o !== 1'b0) begin failures++; $display("FAIL s5_wait_reset cnt/busy/start/en got=%0d/%0b/%0b/%0b exp=0/0/0/0", frame_cnt_o, busy_o, core_start_o, dec_en_o); end
        pulse_done();
        step();
        checks++; if (frame_cnt_o !== 2'd0 || busy_o !== 1'b0) begin failures++; $display("FAIL s5_spurious_done cnt/busy got=%0d/%0b exp=0/0", frame_cnt_o, busy_o); end
    endtask

    task automatic test_wrap_gaps();
        logic [CNT_W-1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [63:0] fr;
        reset = 1'b1;
        step();
        reset = 1'b0; enable_i = 1'b1;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 8; i++) fr[8*i +: 8] = 8'(8'h30 + 8'h10 * f + i);
            clear_log();
            send_frame(fr, f);
            wait_start();
            checks++; if (en_sel.size() != 8) begin failures++; $display("FAIL s6_rows frame=%0d got=%0d exp=8", f, en_sel.size()); end
            for (int i = 0; i < 8 && i < en_sel.size(); i++) begin
                checks++; if (en_sel[i] !== 3'(i) || en_slice[i] !== fr[8*i +: 8]) begin failures++; $display("FAIL s6_row frame=%0d row=%0d got=%0d/%0h exp=%0d/%0h", f, i, en_sel[i], en_slice[i], i, fr[8*i +: 8]); end
            end
            pulse_done();
            checks++; if (frame_cnt_o !== exp_cnt[f]) begin failures++; $display("FAIL s6_frame_cnt frame=%0d got=%0d exp=%0d", f, frame_cnt_o, exp_cnt[f]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_second_frame();
        test_core_busy();
        test_abort();
        test_reset_midframe();
        test_wrap_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
